// File: rtl/serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_add_sub                                                |
// | Purpose  : Bit-serial unsigned adder/subtractor. One operand bit is      |
// |            processed per clock, LSB first, through a single full-adder   |
// |            cell. The result is WIDTH+1 bits wide so that a subtraction   |
// |            yields a two's-complement signed difference.                  |
// | Ports    : clk   - clock, all state changes on the rising edge           |
// |            rst   - synchronous active-high reset                         |
// |            start - begin an operation with the current A, B, sub         |
// |            A, B  - unsigned operands, WIDTH bits                         |
// |            sub   - 0 = A + B, 1 = A - B                                  |
// |            busy  - high while bits are being processed                   |
// |            done  - one-cycle pulse, S/C_out valid                        |
// |            S     - WIDTH+1 bit result, held until the next result        |
// |            C_out - carry out of bit WIDTH-1 (1 = no borrow on subtract)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   S,
    output logic             C_out
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_sub;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_sum_vec;

    // Operand registers shift right, so bit 0 is always the bit in flight.
    // Subtraction inverts B and preloads the carry with 1 (A + ~B + 1).
    assign w_a_bit      = r_a[0];
    assign w_b_bit      = r_b[0] ^ r_sub;
    assign w_sum_bit    = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_carry_next = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);

    // Accumulated sum bits with the current bit merged in at its position;
    // r_sum is cleared on start, so an OR is enough to insert the bit.
    assign w_sum_vec = r_sum | (WIDTH'(w_sum_bit) << r_cnt);

    assign busy = (r_state == c_CALC);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            S       <= '0;
            C_out   <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts start exactly like IDLE so operations can be
                // issued back to back without an idle cycle.
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_CALC;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_CALC: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_next;
                    r_sum   <= w_sum_vec;
                    r_cnt   <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                        // For subtraction the carry out means "no borrow",
                        // so the sign bit of the difference is its inverse.
                        S       <= {(r_sub ? ~w_carry_next : w_carry_next), w_sum_vec};
                        C_out   <= w_carry_next;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
